mic_lpf_decimator: RTL and testbench
====================================

MIC_LPF_DECIMATOR -- requirements
Module: mic_lpf_decimator

Interface
REQ-001 Parameter: DECIM, 8, decimation ratio (power of two, 2..16); one output per DECIM accepted input samples.
REQ-002 Parameter: NTAPS, 31, FIR length (odd, 3..63).
REQ-003 Port: clk_in  input  1  100 MHz system clock; every register SHALL be clocked on its rising edge.
REQ-004 Port: rst_in  input  1  reset; SHALL be synchronous and active-high.
REQ-005 Port: ready_in  input  1  one-cycle strobe at the 48 kHz mic sample rate; mic_in valid in that cycle.
REQ-006 Port: mic_in  input  8  signed PCM mic sample.
REQ-007 Port: filter_in  input  1  1 = low-pass and decimate; 0 = decimate only (bypass).
REQ-008 Port: data_out  output  8  signed decimated PCM sample, held until the next valid_out.
REQ-009 Port: valid_out  output  1  one-cycle strobe for a new data_out; drives the recorder's sample strobe.
REQ-010 Port: busy_out  output  1  high while the MAC is running.
REQ-011 Port: overrun_out  output  1  sticky flag: an input sample was dropped.

Function
REQ-012 The block SHALL keep a circular history buffer of NTAPS signed 8-bit samples and a write pointer that wraps from NTAPS-1 to 0.
REQ-013 A ready_in while not busy SHALL write mic_in at the pointer, advance the pointer, and advance a phase counter modulo DECIM.
REQ-014 The FSM SHALL have states IDLE, MAC and OUT; IDLE->MAC on an accepted sample with phase == DECIM-1 and filter_in=1; MAC->OUT after NTAPS products; OUT->IDLE unconditionally.
REQ-015 MAC SHALL perform one signed 8x10 multiply-accumulate per cycle, newest sample times coef[0] through oldest times coef[NTAPS-1].
REQ-016 The accumulator SHALL be 8+10+ceil(log2(NTAPS)) bits, 23 bits at default, cleared on MAC entry.
REQ-017 In OUT, data_out SHALL be accumulator >>> 10, saturated to [-128,127], and valid_out SHALL pulse.
REQ-018 Filtered latency: valid_out SHALL assert exactly NTAPS+2 cycles after the triggering ready_in cycle.
REQ-019 Bypass: on an accepted sample with phase == DECIM-1, data_out SHALL equal that mic_in and valid_out SHALL pulse one cycle later; the history buffer SHALL still be written.
REQ-020 ready_in during MAC or OUT SHALL drop the sample without touching buffer, pointer or phase, and SHALL set overrun_out.
REQ-021 A change of filter_in SHALL take effect at the next accepted sample; an in-flight MAC SHALL complete.
REQ-022 busy_out SHALL be high exactly in MAC and OUT.

Reset
REQ-023 rst_in SHALL clear the history buffer, write pointer, phase counter, accumulator, data_out, valid_out, busy_out and overrun_out to 0 and force IDLE.
REQ-024 rst_in during MAC SHALL abort the computation with no valid_out pulse.
REQ-025 The first valid_out after reset SHALL follow the DECIM-th accepted sample.

Configuration
REQ-026 With macro MIC_LPF_ROUND_EN defined, OUT SHALL add 2^9 to the accumulator before the shift (round half up), and saturation SHALL follow rounding.
REQ-027 With MIC_LPF_ROUND_EN undefined, OUT SHALL truncate (arithmetic shift only).

Structure
REQ-028 Package mic_lpf_pkg SHALL hold the FSM state typedef, coefficient width (10), coefficient shift (10) and the 31-entry symmetric coefficient table, whose sum SHALL be exactly 1024 (unity DC gain).
REQ-029 Sub-module lpf_coef_rom SHALL return the registered coef[index] one cycle after the index is applied; the MAC pipeline SHALL account for this cycle within REQ-018.

Verification
REQ-030 DC: filter_in=1, mic_in=100 for 64 strobes -> after the first 4 outputs, every data_out = 100 (99 or 100 without MIC_LPF_ROUND_EN).
REQ-031 Nyquist: mic_in alternating +100/-100 for 128 strobes -> steady-state |data_out| <= 2.
REQ-032 Bypass: filter_in=0, mic_in = 0,1,2,...,15 -> two valid_out pulses with data_out 7 then 15, each one cycle after the triggering ready_in.
REQ-033 Saturation: mic_in=127 and then -128 held for 64 strobes each -> data_out settles at 127 then -128, with no wrap to the opposite sign.
REQ-034 Overrun/reset: ready_in 5 cycles after a MAC-triggering strobe -> overrun_out=1 and the output is unchanged; rst_in at MAC cycle 10 -> no valid_out, all outputs 0 the next cycle.

Source files
------------

// File: rtl/mic_lpf_pkg.sv
`timescale 1ns/1ps
// Shared FSM state type, coefficient format and the 31-tap triangular low-pass
// table (sum 1024, so DC gain is exactly one after the >>> 10).
package mic_lpf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } lpf_state_e;

    localparam int COEF_W     = 10;
    localparam int COEF_SHIFT = 10;
    localparam int NUM_COEFS  = 31;
    localparam int ROM_IDX_W  = 6;

    // Even-index and odd-index taps each sum to 512, which nulls the response at Nyquist.
    localparam logic signed [COEF_W-1:0] COEF_TABLE [NUM_COEFS] = '{
        10'sd4,  10'sd8,  10'sd12, 10'sd16, 10'sd20, 10'sd24, 10'sd28, 10'sd32,
        10'sd36, 10'sd40, 10'sd44, 10'sd48, 10'sd52, 10'sd56, 10'sd60, 10'sd64,
        10'sd60, 10'sd56, 10'sd52, 10'sd48, 10'sd44, 10'sd40, 10'sd36, 10'sd32,
        10'sd28, 10'sd24, 10'sd20, 10'sd16, 10'sd12, 10'sd8,  10'sd4
    };

    function automatic logic signed [COEF_W-1:0] coef_at(input logic [ROM_IDX_W-1:0] idx);
        logic signed [COEF_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_COEFS; k++) begin
            if (idx == ROM_IDX_W'(k)) begin
                c = COEF_TABLE[k];
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/lpf_coef_rom.sv
`timescale 1ns/1ps
// Registered coefficient lookup: o_coef holds coef[i_idx] one cycle after i_idx
// is applied; indices past the table read as zero.
module lpf_coef_rom
    import mic_lpf_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [ROM_IDX_W-1:0]        i_idx,
    output logic signed [COEF_W-1:0]    o_coef
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_coef <= '0;
        end else begin
            o_coef <= coef_at(i_idx);
        end
    end

endmodule

// File: rtl/mic_lpf_decimator.sv
`timescale 1ns/1ps
// Mic-rate FIR low-pass plus DECIM:1 decimator with a serial MAC and bypass mode.
// Optional: define MIC_LPF_ROUND_EN to round half up before the output shift.
module mic_lpf_decimator
    import mic_lpf_pkg::*;
#(
    parameter int DECIM = 8,
    parameter int NTAPS = 31
)
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              ready_in,
    input  logic signed [7:0] mic_in,
    input  logic              filter_in,
    output logic signed [7:0] data_out,
    output logic              valid_out,
    output logic              busy_out,
    output logic              overrun_out
);

    localparam int ACC_W  = 8 + COEF_W + $clog2(NTAPS);
    localparam int PROD_W = 8 + COEF_W;
    localparam int PTR_W  = $clog2(NTAPS);
    localparam int CNT_W  = $clog2(NTAPS + 1);
    localparam int PH_W   = $clog2(DECIM);

    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-128);
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1 << (COEF_SHIFT - 1));

    lpf_state_e                 r_state;
    lpf_state_e                 w_next_state;
    logic signed [7:0]          r_buf [NTAPS];
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [PH_W-1:0]            r_phase;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_acc_en;
    logic signed [7:0]          r_samp;
    logic signed [ACC_W-1:0]    r_acc;

    logic                       w_accept;
    logic                       w_last_phase;
    logic                       w_trigger;
    logic                       w_bypass;
    logic                       w_mac_done;
    logic [ROM_IDX_W-1:0]       w_rom_idx;
    logic signed [COEF_W-1:0]   w_coef;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [ACC_W-1:0]    w_rounded;
    logic signed [ACC_W-1:0]    w_shifted;

    function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
        logic signed [7:0] res;
        if (v > SAT_MAX) begin
            res = 8'h7F;
        end else if (v < SAT_MIN) begin
            res = 8'h80;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    assign w_accept     = ready_in && (r_state == ST_IDLE);
    assign w_last_phase = (r_phase == PH_W'(DECIM - 1));
    assign w_trigger    = w_accept && w_last_phase && filter_in;
    assign w_bypass     = w_accept && w_last_phase && !filter_in;
    assign w_mac_done   = (r_state == ST_MAC) && (r_cnt == CNT_W'(NTAPS));
    assign w_rom_idx    = ROM_IDX_W'(r_cnt);

    // The ROM output lags r_cnt by one cycle, matching the r_samp register below.
    lpf_coef_rom u_coef_rom (
        .i_clk  (clk_in),
        .i_rst  (rst_in),
        .i_idx  (w_rom_idx),
        .o_coef (w_coef)
    );

    assign w_prod     = r_samp * w_coef;
    assign w_acc_next = r_acc + {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef MIC_LPF_ROUND_EN
    assign w_rounded = w_acc_next + ROUND_BIAS;
`else
    assign w_rounded = w_acc_next;
`endif

    assign w_shifted = w_rounded >>> COEF_SHIFT;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_next_state = ST_MAC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (w_mac_done) begin
                    w_next_state = ST_OUT;
                end else begin
                    w_next_state = ST_MAC;
                end
            end
            ST_OUT:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // History buffer, write pointer and decimation phase advance only on accepted samples.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_buf[k] <= '0;
            end
            r_wptr  <= '0;
            r_phase <= '0;
        end else if (w_accept) begin
            r_buf[r_wptr] <= mic_in;
            r_wptr  <= (r_wptr == PTR_W'(NTAPS - 1)) ? '0 : r_wptr + PTR_W'(1);
            r_phase <= w_last_phase ? '0 : r_phase + PH_W'(1);
        end else begin
            r_wptr  <= r_wptr;
            r_phase <= r_phase;
        end
    end

    // Serial MAC: fetch newest-to-oldest for NTAPS cycles, accumulate one cycle behind.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_acc_en <= 1'b0;
            r_samp   <= '0;
            r_acc    <= '0;
        end else if (w_trigger) begin
            r_rptr   <= r_wptr;
            r_cnt    <= '0;
            r_acc_en <= 1'b0;
            r_acc    <= '0;
        end else if (r_state == ST_MAC) begin
            if (r_cnt < CNT_W'(NTAPS)) begin
                r_samp   <= r_buf[r_rptr];
                r_rptr   <= (r_rptr == '0) ? PTR_W'(NTAPS - 1) : r_rptr - PTR_W'(1);
                r_cnt    <= r_cnt + CNT_W'(1);
                r_acc_en <= 1'b1;
            end else begin
                r_acc_en <= 1'b0;
            end
            if (r_acc_en) begin
                r_acc <= w_acc_next;
            end else begin
                r_acc <= r_acc;
            end
        end else begin
            r_acc_en <= 1'b0;
        end
    end

    // Output register: the final product is folded in on the way into OUT so valid_out is high during OUT.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            busy_out <= (w_next_state != ST_IDLE);
            if (w_bypass) begin
                data_out  <= mic_in;
                valid_out <= 1'b1;
            end else if (w_mac_done) begin
                data_out  <= sat8(w_shifted);
                valid_out <= 1'b1;
            end else begin
                data_out  <= data_out;
                valid_out <= 1'b0;
            end
            if (ready_in && (r_state != ST_IDLE)) begin
                overrun_out <= 1'b1;
            end else begin
                overrun_out <= overrun_out;
            end
        end
    end

endmodule

// File: tb/tb_mic_lpf_decimator.sv
`timescale 1ns/1ps
// Directed bench for mic_lpf_decimator: reset, bypass, DC, Nyquist, saturation,
// overrun and mid-MAC reset, with hand-computed expectations.
module tb_mic_lpf_decimator;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              ready_in = 1'b0;
    logic signed [7:0] mic_in = '0;
    logic              filter_in = 1'b0;
    logic signed [7:0] data_out;
    logic              valid_out;
    logic              busy_out;
    logic              overrun_out;

    int n_cmp = 0;
    int n_err = 0;

    // Expected outputs for a DC input of 100: floor(100 * partial_coef_sum / 1024)
    // with partial sums 144, 544, 912 and 1024 once the history is full.
    int dc_exp [8] = '{14, 53, 89, 100, 100, 100, 100, 100};

    mic_lpf_decimator #(.DECIM(8), .NTAPS(31)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ready_in    (ready_in),
        .mic_in      (mic_in),
        .filter_in   (filter_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        ready_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // One-cycle strobe; returns at the falling edge of the following cycle.
    task automatic pulse(input logic signed [7:0] m);
        @(negedge clk_in);
        ready_in = 1'b1;
        mic_in   = m;
        @(negedge clk_in);
        ready_in = 1'b0;
    endtask

    // Observe ncyc falling edges starting at the current one; off = index of first valid_out.
    task automatic watch(input int ncyc, output int off, output logic signed [7:0] d, output int np);
        off = -1;
        d   = '0;
        np  = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk_in);
            if (valid_out === 1'b1) begin
                np++;
                if (off < 0) begin
                    off = i;
                    d   = data_out;
                end
            end
        end
    endtask

    task automatic send(input logic signed [7:0] m, output int off, output logic signed [7:0] d, output int np);
        pulse(m);
        watch(40, off, d, np);
    endtask

    initial begin
        int                off;
        int                np;
        logic signed [7:0] d;
        logic signed [7:0] m;

        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_data", data_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_overrun", overrun_out, 0);
        do_reset();

        // Bypass: ramp 0..15, outputs 7 and 15 one cycle after their strobes
        filter_in = 1'b0;
        for (int s = 0; s < 16; s++) begin
            send(8'(s), off, d, np);
            if ((s % 8) == 7) begin
                check("byp_lat", off, 0);
                check("byp_data", d, s);
                check("byp_npulse", np, 1);
            end else begin
                check("byp_none", np, 0);
            end
        end
        check("byp_overrun", overrun_out, 0);

        // DC 100 through the filter
        do_reset();
        filter_in = 1'b1;
        for (int s = 0; s < 64; s++) begin
            send(8'sd100, off, d, np);
            if ((s % 8) == 7) begin
                check("dc_lat", off, 32);
                check("dc_data", d, dc_exp[s / 8]);
                check("dc_npulse", np, 1);
            end else begin
                check("dc_none", np, 0);
            end
        end

        // Nyquist: alternating +-100 is nulled once the history is full
        do_reset();
        for (int s = 0; s < 128; s++) begin
            m = ((s % 2) == 0) ? 8'sd100 : -8'sd100;
            send(m, off, d, np);
            if (((s % 8) == 7) && (s >= 31)) begin
                check("nyq_data", d, 0);
                check("nyq_npulse", np, 1);
            end
        end

        // Saturation: +127 then -128 held
        do_reset();
        for (int s = 0; s < 128; s++) begin
            m = (s < 64) ? 8'sd127 : 8'h80;
            send(m, off, d, np);
            if ((s % 8) == 7) begin
                if (s < 64) begin
                    check("sat_pos_sign", (d >= 0) ? 1 : 0, 1);
                end else begin
                    check("sat_npulse", np, 1);
                end
                if ((s % 64) >= 31) begin
                    check("sat_level", d, (s < 64) ? 127 : -128);
                end
            end
        end

        // Overrun: a strobe 5 cycles into the MAC is dropped
        do_reset();
        filter_in = 1'b1;
        for (int s = 0; s < 7; s++) begin
            send(8'sd100, off, d, np);
        end
        pulse(8'sd100);
        check("ovr_busy", busy_out, 1);
        repeat (4) @(negedge clk_in);
        ready_in = 1'b1;
        mic_in   = 8'h80;
        @(negedge clk_in);
        ready_in  = 1'b0;
        filter_in = 1'b0;
        check("ovr_flag", overrun_out, 1);
        check("ovr_data_held", data_out, 0);
        check("ovr_valid", valid_out, 0);
        watch(35, off, d, np);
        check("ovr_lat", off, 27);
        check("ovr_data", d, 14);
        filter_in = 1'b1;
        for (int s = 0; s < 8; s++) begin
            send(8'sd100, off, d, np);
            if (s == 7) begin
                check("ovr_next_lat", off, 32);
                check("ovr_next_data", d, 53);
            end else begin
                check("ovr_next_none", np, 0);
            end
        end
        check("ovr_sticky", overrun_out, 1);

        // Reset during MAC cycle 10 aborts the computation
        for (int s = 0; s < 7; s++) begin
            send(8'sd100, off, d, np);
        end
        pulse(8'sd100);
        repeat (9) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("mrst_data", data_out, 0);
        check("mrst_valid", valid_out, 0);
        check("mrst_busy", busy_out, 0);
        check("mrst_overrun", overrun_out, 0);
        watch(40, off, d, np);
        check("mrst_no_valid", np, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
